// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: sequencer for a 4-digit multiplexed hex display.
// Walks the enabled digits in ascending order. Each digit gets an all-off
// blanking gap followed by a lit period. The 16-bit value and the dp mask
// are snapshotted once per frame so a digit never shows a half-updated word.
module display_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,  // cycles each digit stays lit (>= 1)
    parameter int BLANK_CYCLES = 1000,    // all-off cycles before each digit
    parameter int CNT_W        = 17       // 2^CNT_W > max(REFRESH_DIV, BLANK_CYCLES)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [3:0]  digit_en,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic [1:0]  contador,
    output logic [3:0]  nibble,
    output logic        dp,
    output logic [3:0]  AN,
    output logic        frame_tick
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } state_t;

    // Terminal counts. The blanking terminal is only used when a gap exists.
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST =
        CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      shadow;
    logic [3:0]       shadow_dp;

    // Lowest set bit of the mask (0 for an empty mask; callers never pass one).
    function automatic logic [1:0] lowest_idx(input logic [3:0] mask);
        lowest_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) lowest_idx = 2'(i);
        end
    endfunction

    // Next enabled index strictly above cur, wrapping to the lowest enabled one.
    function automatic logic [1:0] next_idx(input logic [1:0] cur,
                                            input logic [3:0] mask);
        next_idx = lowest_idx(mask);
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) next_idx = 2'(i);
        end
    endfunction

    function automatic logic [3:0] one_hot(input logic [1:0] idx);
        one_hot = 4'b0001 << idx;
    endfunction

    function automatic logic [3:0] pick_nibble(input logic [15:0] word,
                                               input logic [1:0]  idx);
        pick_nibble = word[{idx, 2'b00} +: 4];
    endfunction

    // Scan FSM: state, cycle counter, frame shadow and all registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: state and outputs use non-blocking assignments so every register
        // samples the pre-edge values; blocking here would chain updates within
        // one edge and break the simulation/synthesis match.
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            contador   <= 2'd0;
            nibble     <= 4'd0;
            dp         <= 1'b0;
            AN         <= 4'd0;
            frame_tick <= 1'b0;
            shadow     <= 16'd0;
            shadow_dp  <= 4'd0;
        end else if (!enable || (digit_en == 4'd0)) begin
            // Go dark immediately; contador (and its nibble/dp) is held.
            state      <= IDLE;
            cnt        <= '0;
            AN         <= 4'd0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            case (state)
                IDLE: begin
                    // Start of a fresh frame at the lowest enabled digit.
                    shadow     <= value;
                    shadow_dp  <= dp_in;
                    frame_tick <= 1'b1;
                    contador   <= lowest_idx(digit_en);
                    nibble     <= pick_nibble(value, lowest_idx(digit_en));
                    dp         <= dp_in[lowest_idx(digit_en)];
                    cnt        <= '0;
                    if (HAS_BLANK) begin
                        state <= BLANK;
                        AN    <= 4'd0;
                    end else begin
                        state <= ON;
                        AN    <= one_hot(lowest_idx(digit_en));
                    end
                end

                BLANK: begin
                    // Anodes off; contador/nibble/dp already show the next digit.
                    if (cnt == BLANK_LAST) begin
                        state <= ON;
                        cnt   <= '0;
                        AN    <= one_hot(contador);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ON: begin
                    if (cnt == ON_LAST) begin
                        cnt      <= '0;
                        contador <= next_idx(contador, digit_en);
                        if (next_idx(contador, digit_en) <= contador) begin
                            // Wrap: the new frame's snapshot is taken together
                            // with the index update so the first digit is coherent.
                            shadow     <= value;
                            shadow_dp  <= dp_in;
                            frame_tick <= 1'b1;
                            nibble     <= pick_nibble(value, next_idx(contador, digit_en));
                            dp         <= dp_in[next_idx(contador, digit_en)];
                        end else begin
                            nibble     <= pick_nibble(shadow, next_idx(contador, digit_en));
                            dp         <= shadow_dp[next_idx(contador, digit_en)];
                        end
                        if (HAS_BLANK) begin
                            state <= BLANK;
                            AN    <= 4'd0;
                        end else begin
                            state <= ON;
                            AN    <= one_hot(next_idx(contador, digit_en));
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    AN    <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed vector table, hand-written corner sequences
// and a randomized run, all compared against a slot-based reference model.
module tb_display_scan_ctrl;

    localparam int R    = 4;      // REFRESH_DIV
    localparam int B    = 2;      // BLANK_CYCLES
    localparam int SLOT = R + B;  // cycles one digit occupies in a frame

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [3:0]  digit_en;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [1:0]  contador;
    logic [3:0]  nibble;
    logic        dp;
    logic [3:0]  AN;
    logic        frame_tick;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    display_scan_ctrl #(.REFRESH_DIV(R), .BLANK_CYCLES(B), .CNT_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .digit_en   (digit_en),
        .value      (value),
        .dp_in      (dp_in),
        .contador   (contador),
        .nibble     (nibble),
        .dp         (dp),
        .AN         (AN),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Reference model: a frame is a sequence of slots; position m_t inside
    // the current slot decides whether the anode is lit.
    bit          m_run;
    int          m_t;
    int          m_idx;
    logic [15:0] m_sh;
    logic [3:0]  m_shdp;
    bit          m_tick;

    task automatic model_step();
        int lo, nx;
        lo = 0;
        for (int k = 0; k < 4; k++) if (digit_en[k]) begin lo = k; break; end
        if (!reset_n) begin
            m_run = 0; m_t = 0; m_idx = 0; m_sh = '0; m_shdp = '0; m_tick = 0;
        end else if (!enable || digit_en == 4'd0) begin
            m_run = 0; m_t = 0; m_tick = 0;
        end else if (!m_run) begin
            m_run = 1; m_t = 0; m_idx = lo; m_sh = value; m_shdp = dp_in; m_tick = 1;
        end else if (m_t == SLOT - 1) begin
            nx = lo;
            for (int k = 3; k > m_idx; k--) if (digit_en[k]) nx = k;
            m_tick = (nx <= m_idx);
            if (m_tick) begin m_sh = value; m_shdp = dp_in; end
            m_idx = nx; m_t = 0;
        end else begin
            m_t++; m_tick = 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock: model advances on the edge, DUT is compared on the falling edge.
    task automatic step();
        logic [3:0] e_an;
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        e_an = (m_run && m_t >= B) ? (4'b0001 << m_idx) : 4'b0000;
        check("model", {20'd0, AN, contador, nibble, dp, frame_tick},
              {20'd0, e_an, 2'(m_idx), 4'((m_sh >> (4 * m_idx)) & 16'hF),
               m_shdp[m_idx], m_tick});
    endtask

    typedef struct packed {
        logic        rst_n;
        logic        en;
        logic [3:0]  mask;
        logic [15:0] val;
        logic [3:0]  dpi;
        logic [3:0]  an;
        logic [1:0]  cnt;
        logic [3:0]  nib;
        logic        dpo;
        logic        tick;
    } vec_t;

    vec_t table_q[$];

    task automatic add(input int n, input logic rst_n, input logic [3:0] an,
                       input logic [1:0] cnt, input logic [3:0] nib,
                       input logic dpo, input logic tick);
        vec_t v;
        v = '{rst_n: rst_n, en: 1'b1, mask: 4'hF, val: 16'hA5C3, dpi: 4'b0100,
              an: an, cnt: cnt, nib: nib, dpo: dpo, tick: tick};
        for (int i = 0; i < n; i++) table_q.push_back(v);
    endtask

    initial begin
        bit          seen;
        int          last_tick, ticks, lit;
        logic [15:0] word;

        // Reset for 3 edges, then the first full frame of A5C3 and the wrap.
        add(3, 1'b0, 4'b0000, 2'd0, 4'h0, 1'b0, 1'b0);
        add(1, 1'b1, 4'b0000, 2'd0, 4'h3, 1'b0, 1'b1);
        add(1, 1'b1, 4'b0000, 2'd0, 4'h3, 1'b0, 1'b0);
        add(4, 1'b1, 4'b0001, 2'd0, 4'h3, 1'b0, 1'b0);
        add(2, 1'b1, 4'b0000, 2'd1, 4'hC, 1'b0, 1'b0);
        add(4, 1'b1, 4'b0010, 2'd1, 4'hC, 1'b0, 1'b0);
        add(2, 1'b1, 4'b0000, 2'd2, 4'h5, 1'b1, 1'b0);
        add(4, 1'b1, 4'b0100, 2'd2, 4'h5, 1'b1, 1'b0);
        add(2, 1'b1, 4'b0000, 2'd3, 4'hA, 1'b0, 1'b0);
        add(4, 1'b1, 4'b1000, 2'd3, 4'hA, 1'b0, 1'b0);
        add(1, 1'b1, 4'b0000, 2'd0, 4'h3, 1'b0, 1'b1);

        reset_n = 1'b0; enable = 1'b1; digit_en = 4'hF; value = 16'hA5C3; dp_in = 4'b0100;

        foreach (table_q[i]) begin
            reset_n  = table_q[i].rst_n;
            enable   = table_q[i].en;
            digit_en = table_q[i].mask;
            value    = table_q[i].val;
            dp_in    = table_q[i].dpi;
            step();
            check($sformatf("table[%0d]", i), {23'd0, AN, contador, nibble, dp, frame_tick},
                  {23'd0, table_q[i].an, table_q[i].cnt, table_q[i].nib,
                   table_q[i].dpo, table_q[i].tick});
        end

        // No tearing: change value while digit 1 is lit.
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin step(); seen = (AN == 4'b0010); end
        check("reach_digit1", 32'(seen), 32'd1);
        value = 16'h1234;
        word  = 16'hA5C3;
        seen  = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            seen = frame_tick;
            if (!seen && AN != 4'd0)
                check("old_frame_nibble", 32'(nibble), 32'((word >> (4 * contador)) & 16'hF));
        end
        check("tearing_tick_seen", 32'(seen), 32'd1);
        word = 16'h1234;
        for (int i = 0; i < 24; i++) begin
            step();
            if (AN != 4'd0)
                check("new_frame_nibble", 32'(nibble), 32'((word >> (4 * contador)) & 16'hF));
        end

        // Mask 0101: digits 0 and 2 only, 12-cycle frames.
        digit_en = 4'b0101;
        for (int i = 0; i < 30; i++) step();
        last_tick = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            check("mask_an", 32'(AN == 4'b0000 || AN == 4'b0001 || AN == 4'b0100), 32'd1);
            if (frame_tick) begin
                if (last_tick >= 0) check("mask_period", 32'(cyc - last_tick), 32'd12);
                last_tick = cyc;
            end
        end

        // Enable drop during digit 2 ON, then restart at digit 0.
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin step(); seen = (contador == 2'd2 && AN != 4'd0); end
        check("reach_digit2", 32'(seen), 32'd1);
        enable = 1'b0;
        step();
        check("drop_an", 32'(AN), 32'd0);
        check("drop_cnt_held", 32'(contador), 32'd2);
        step(); step();
        check("idle_an", 32'(AN), 32'd0);
        enable = 1'b1;
        step();
        check("restart_tick", 32'(frame_tick), 32'd1);
        check("restart_cnt", 32'(contador), 32'd0);
        step(); step();
        check("restart_an", 32'(AN), 32'b0001);

        // Single digit 3: BLANK/ON alternation with a wrap every slot.
        digit_en = 4'b1000;
        for (int i = 0; i < 12; i++) step();
        ticks = 0; lit = 0;
        for (int i = 0; i < 18; i++) begin
            step();
            check("single_cnt", 32'(contador), 32'd3);
            ticks += int'(frame_tick);
            lit   += int'(AN == 4'b1000);
        end
        check("single_ticks", 32'(ticks), 32'd3);
        check("single_lit", 32'(lit), 32'd12);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            enable  = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 29) == 0) digit_en = 4'($urandom);
            if ($urandom_range(0, 4) == 0)  value    = 16'($urandom);
            if ($urandom_range(0, 9) == 0)  dp_in    = 4'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
